// File: rtl/spi_cmd_pkg.sv
// Shared command encodings, FSM state type and command word layout for the
// SPI command decoder / register bank.
package spi_cmd_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned RESP_W = 24;

    localparam logic [1:0] CMD_NOP       = 2'b00;
    localparam logic [1:0] CMD_WRITE     = 2'b01;
    localparam logic [1:0] CMD_READ      = 2'b10;
    localparam logic [1:0] CMD_WRITE_INV = 2'b11;

    localparam logic [ADDR_W-1:0] ERR_ADDR     = 6'd63;
    localparam logic [RESP_W-1:0] INVALID_RESP = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Received word: [31:8] payload, [7:6] command, [5:0] address.
    typedef struct packed {
        logic [RESP_W-1:0] payload;
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } cmd_word_t;

endpackage

// File: rtl/spi_cmd_regbank.sv
// Register array with indexed (optionally inverted) write; exposes the
// flattened register bus and a one-cycle write pulse per register.
module spi_cmd_regbank
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned REG_W     = 24,
    parameter logic [23:0] RESET_VAL = 24'h0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         idx_i,
    input  logic [REG_W-1:0]          data_i,
    input  logic                      inv_i,
    output logic [NUM_REGS*REG_W-1:0] reg_out_o,
    output logic [NUM_REGS-1:0]       reg_wr_o
);

    localparam logic [REG_W-1:0] RST_V = REG_W'(RESET_VAL);

    logic [REG_W-1:0]    regs_q [NUM_REGS];
    logic [REG_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_q;
    logic [NUM_REGS-1:0] reg_wr_d;
    logic [REG_W-1:0]    wdata_c;

    always_comb begin
        regs_d   = regs_q;
        reg_wr_d = '0;
        wdata_c  = inv_i ? ~data_i : data_i;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (we_i && (idx_i == ADDR_W'(i))) begin
                regs_d[i]   = wdata_c;
                reg_wr_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_V;
            end
            reg_wr_q <= '0;
        end else begin
            regs_q   <= regs_d;
            reg_wr_q <= reg_wr_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out_o[g*REG_W +: REG_W] = regs_q[g];
    end

    assign reg_wr_o = reg_wr_q;

endmodule

// File: rtl/spi_cmd_regfile.sv
// Command decoder between the spi_slave word interface and a register bank.
// Define SPI_CMD_ERRCNT_EN to map an invalid-access counter at address 63.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned REG_W     = 24,
    parameter logic [23:0] RESET_VAL = 24'h0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rd_data_available,
    input  logic [WORD_W-1:0]         rd_data,
    output logic                      rd_ack,
    input  logic                      wr_buffer_free,
    output logic                      wr_en,
    output logic [RESP_W-1:0]         wr_data,
    output logic [NUM_REGS*REG_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]       reg_wr
);

    state_e            state_q, state_d;
    cmd_word_t         word_q, word_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_en_q, wr_en_d;
    logic [RESP_W-1:0] wr_data_q, wr_data_d;
    logic              we_c;
    logic              inv_c;
    logic              addr_valid_c;
    logic [REG_W-1:0]  rd_val_c;
`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              is_status_c;
`endif

    spi_cmd_regbank #(
        .NUM_REGS  (NUM_REGS),
        .REG_W     (REG_W),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .clk       (clk),
        .resetn    (resetn),
        .we_i      (we_c),
        .idx_i     (word_q.addr),
        .data_i    (REG_W'(word_q.payload)),
        .inv_i     (inv_c),
        .reg_out_o (reg_out),
        .reg_wr_o  (reg_wr)
    );

    // Address decode and read mux for the latched command word.
    always_comb begin
        addr_valid_c = (32'(word_q.addr) < NUM_REGS);
        rd_val_c     = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (word_q.addr == ADDR_W'(i)) begin
                rd_val_c = reg_out[i*REG_W +: REG_W];
            end
        end
    end

`ifdef SPI_CMD_ERRCNT_EN
    assign is_status_c = (word_q.addr == ERR_ADDR);
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        rd_ack_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        we_c      = 1'b0;
        inv_c     = 1'b0;
`ifdef SPI_CMD_ERRCNT_EN
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_data_available) begin
                    word_d   = cmd_word_t'(rd_data);
                    rd_ack_d = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (word_q.cmd)
                    CMD_WRITE, CMD_WRITE_INV: begin
                        inv_c   = (word_q.cmd == CMD_WRITE_INV);
                        we_c    = addr_valid_c;
                        state_d = ST_IDLE;
`ifdef SPI_CMD_ERRCNT_EN
                        if (is_status_c) begin
                            err_cnt_d = '0;
                        end else if (!addr_valid_c && (err_cnt_q != 8'hFF)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
`endif
                    end
                    CMD_READ: begin
                        wr_data_d = addr_valid_c ? RESP_W'(rd_val_c) : INVALID_RESP;
                        state_d   = ST_RESP;
`ifdef SPI_CMD_ERRCNT_EN
                        if (is_status_c) begin
                            wr_data_d = {16'b0, err_cnt_q};
                        end else if (!addr_valid_c && (err_cnt_q != 8'hFF)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
`endif
                    end
                    CMD_NOP: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_RESP: begin
                // Hold the captured response until the slave can take it.
                if (wr_buffer_free) begin
                    wr_en_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            rd_ack_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
`ifdef SPI_CMD_ERRCNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            rd_ack_q  <= rd_ack_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
`ifdef SPI_CMD_ERRCNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign rd_ack  = rd_ack_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Scoreboard bench for spi_cmd_regfile (NUM_REGS=4, REG_W=24, RESET_VAL=5).
module tb_spi_cmd_regfile;

    localparam int unsigned NR = 4;
    localparam int unsigned RW = 24;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           avail = 1'b0;
    logic           free = 1'b1;
    logic [31:0]    rd_data = '0;
    logic           rd_ack;
    logic           wr_en;
    logic [23:0]    wr_data;
    logic [NR*RW-1:0] reg_out;
    logic [NR-1:0]  reg_wr;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] sb_q[$];
    logic [23:0] model [NR];
    logic        prev_ack = 1'b0;

    spi_cmd_regfile #(
        .NUM_REGS  (NR),
        .REG_W     (RW),
        .RESET_VAL (24'h000005)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .rd_data_available (avail),
        .rd_data           (rd_data),
        .rd_ack            (rd_ack),
        .wr_buffer_free    (free),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .reg_out           (reg_out),
        .reg_wr            (reg_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [95:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Response monitor: every wr_en must match the oldest expected response.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) chk("wr_en_spurious", 96'(1), 96'(0));
            else chk("resp_data", 96'(wr_data), 96'(sb_q.pop_front()));
        end
        if (rd_ack === 1'b1) chk("ack_back_to_back", 96'(prev_ack), 96'(0));
        prev_ack = rd_ack;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        rd_data = w;
        avail = 1'b1;
        @(negedge clk);
        while (rd_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", 96'(rd_ack), 96'(1));
        avail = 1'b0;
    endtask

    task automatic wait_resp(input int exp_lat);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_latency", 96'(n), 96'(exp_lat));
    endtask

    task automatic do_write(input logic [31:0] w);
        logic [5:0]  addr;
        logic [3:0]  mask;
        addr = w[5:0];
        mask = (addr < 6'(NR)) ? 4'(1 << addr) : 4'h0;
        send_word(w);
        @(negedge clk);
        chk("reg_wr_early", 96'(reg_wr), 96'(0));
        if (addr < 6'(NR)) model[addr[1:0]] = (w[7:6] == 2'b11) ? ~w[31:8] : w[31:8];
        @(negedge clk);
        chk("reg_wr_pulse", 96'(reg_wr), 96'(mask));
        chk("reg_out", reg_out, model_flat());
        @(negedge clk);
        chk("reg_wr_len", 96'(reg_wr), 96'(0));
    endtask

    task automatic do_read(input logic [31:0] w, input logic [23:0] exp);
        sb_q.push_back(exp);
        send_word(w);
        wait_resp(3);
    endtask

    initial begin
        int bad_wr;
        int bad_ack;
        logic [5:0]  ra;
        logic [23:0] pl;
        logic [1:0]  cm;

        for (int i = 0; i < int'(NR); i++) model[i] = 24'h000005;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_reg_out", reg_out, model_flat());
        chk("rst_rd_ack", 96'(rd_ack), 96'(0));
        chk("rst_wr_en", 96'(wr_en), 96'(0));
        chk("rst_reg_wr", 96'(reg_wr), 96'(0));
        chk("rst_wr_data", 96'(wr_data), 96'(0));
        resetn = 1'b1;
        @(negedge clk);

        // Write, read back, inverted write, reset value read
        do_write(32'h1234_5641);
        do_read(32'h0000_0081, 24'h123456);
        do_write(32'h00FF_00C2);
        do_read(32'h0000_0082, 24'hFF00FF);
        do_read(32'h0000_0080, 24'h000005);

        // NOP leaves everything untouched
        send_word(32'hFFFF_FF00);
        bad_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_wr !== 4'h0 || wr_en !== 1'b0) bad_wr++;
        end
        chk("nop_no_effect", 96'(bad_wr), 96'(0));
        chk("nop_reg_out", reg_out, model_flat());

        // Back-pressure with a second word waiting
        free = 1'b0;
        sb_q.push_back(24'h123456);
        send_word(32'h0000_0081);
        rd_data = 32'h0000_0082;
        avail = 1'b1;
        bad_wr = 0;
        bad_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en !== 1'b0) bad_wr++;
            if (rd_ack !== 1'b0) bad_ack++;
        end
        chk("bp_hold_wr_en", 96'(bad_wr), 96'(0));
        chk("bp_hold_ack", 96'(bad_ack), 96'(0));
        sb_q.push_back(24'hFF00FF);
        free = 1'b1;
        @(negedge clk);
        chk("bp_wr_en", 96'(wr_en), 96'(1));
        chk("bp_ack_not_yet", 96'(rd_ack), 96'(0));
        @(negedge clk);
        chk("bp_second_ack", 96'(rd_ack), 96'(1));
        chk("bp_wr_en_single", 96'(wr_en), 96'(0));
        avail = 1'b0;
        wait_resp(3);

        // Invalid addresses and the status register
        do_read(32'h0000_008A, 24'hFFFFFF);
`ifdef SPI_CMD_ERRCNT_EN
        do_read(32'h0000_00BF, 24'h000001);
        do_write(32'h0000_007F);
        do_read(32'h0000_00BF, 24'h000000);
`else
        do_read(32'h0000_00BF, 24'hFFFFFF);
        do_write(32'h0000_007F);
`endif
        do_write(32'hABCD_EF45);

        // Random write / read-back pairs
        for (int k = 0; k < 8; k++) begin
            ra = 6'($urandom_range(0, NR - 1));
            pl = 24'($urandom);
            cm = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            do_write({pl, cm, ra});
            do_read({24'h0, 2'b10, ra}, model[ra[1:0]]);
        end

        // Reset while a response is stalled in RESP
        free = 1'b0;
        send_word(32'h0000_0081);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(NR); i++) model[i] = 24'h000005;
        chk("rst_resp_reg_out", reg_out, model_flat());
        chk("rst_resp_wr_data", 96'(wr_data), 96'(0));
        chk("rst_resp_rd_ack", 96'(rd_ack), 96'(0));
        resetn = 1'b1;
        free = 1'b1;
        bad_wr = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en !== 1'b0) bad_wr++;
        end
        chk("rst_resp_dropped", 96'(bad_wr), 96'(0));
        do_read(32'h0000_0081, 24'h000005);

        chk("sb_empty", 96'(sb_q.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_regfile.md
# spi_cmd_regfile

Parametrised command decoder and register bank between the `spi_slave` word interface and user logic. It accepts 32-bit command words as opcode byte plus 24-bit payload, and executes write, inverted-write and read operations against `NUM_REGS` registers. It returns read responses as 24-bit words and respects `wr_buffer_free` back-pressure. It sits in `top`, replacing the hard-coded opcode handling; LEDs and other controls are driven from `reg_out` slices.

## Interface
- `NUM_REGS`, default 4: number of registers, legal 1..63.
- `REG_W`, default 24: register width, legal 1..24.
- `RESET_VAL`, default 0: reset value of every register, truncated to `REG_W`.
- `clk`  in  1  system clock.
- `resetn`  in  1  one clock; reset is synchronous and active-low.
- `rd_data_available`  in  1  `spi_slave` has a received word.
- `rd_data`  in  32  received word: [7:6] command, [5:0] address, [31:8] payload.
- `rd_ack`  out  1  one-cycle acknowledge of `rd_data`.
- `wr_buffer_free`  in  1  `spi_slave` can accept a response word.
- `wr_en`  out  1  one-cycle response strobe.
- `wr_data`  out  24  response word, valid while `wr_en`=1.
- `reg_out`  out  `NUM_REGS*REG_W`  flattened registers; register i is at [i*REG_W +: REG_W].
- `reg_wr`  out  `NUM_REGS`  one-cycle pulse on bit i when register i is written.

## Operation
- Commands, from [7:6]:
  - 00 NOP: no action.
  - 01 WRITE: reg[addr] <= payload[REG_W-1:0].
  - 10 READ: respond with the register zero-extended to 24 bits.
  - 11 WRITE_INV: reg[addr] <= ~payload[REG_W-1:0].
- Valid address: addr < `NUM_REGS`.
  - Invalid write: ignored, no `reg_wr` pulse.
  - Invalid read: responds 24'hFFFFFF.
- FSM states IDLE, ACK, EXEC, RESP.
  - IDLE, `rd_data_available`=1: latch `rd_data`; go to ACK.
  - ACK: `rd_ack`=1; go to EXEC.
  - EXEC:
    - write or WRITE_INV: update the register, pulse `reg_wr`, go to IDLE.
    - READ: load the response register, go to RESP.
    - NOP: go to IDLE.
  - RESP, `wr_buffer_free`=1: `wr_en`=1 for one cycle; go to IDLE.
  - RESP, `wr_buffer_free`=0: hold in RESP indefinitely. The response is never dropped.
- Outside IDLE, `rd_data_available` is ignored and the pending word stays in `spi_slave`, which provides natural back-pressure.
- Response data is captured in EXEC. A write arriving after that cannot change a pending response.
- Reset, including reset mid-operation:
  - state returns to IDLE;
  - all registers return to `RESET_VAL`;
  - `rd_ack`, `wr_en` and `reg_wr` are 0; `wr_data` is 0;
  - any pending response is discarded.

## Timing
- All outputs are registered.
- Word seen in IDLE at cycle t:
  - `rd_ack` is high during t+1 only.
  - EXEC is at t+2.
  - A written value appears on `reg_out` at t+3, with `reg_wr` high during t+3.
  - Read: RESP is at t+3, and `wr_en` is high at t+4 at the earliest (if free).
- Minimum command spacing: write or NOP 3 cycles, read 4 cycles.
- `rd_ack` is never asserted on two consecutive cycles.
- `wr_en` is never asserted twice per command.

## Configuration
- `SPI_CMD_ERRCNT_EN` defined: address 63 is a status register.
  - 8-bit saturating error counter.
  - Increments on every access to an invalid address (1..62 range ≥ `NUM_REGS`).
  - READ of address 63 returns {16'b0, err_cnt}.
  - WRITE or WRITE_INV to address 63 clears the counter.
  - Counter resets to 0.
- Macro undefined: address 63 behaves as any invalid address, and no counter logic exists.

## Structure
- Package `spi_cmd_pkg` holds:
  - command localparams (CMD_NOP, CMD_WRITE, CMD_READ, CMD_WRITE_INV);
  - the FSM state encoding;
  - ERR_ADDR=63;
  - INVALID_RESP=24'hFFFFFF.
- One sub-module, `spi_cmd_regbank`: a register array with write-enable, index, data and optional invert. It outputs the flattened bus and per-register pulses.
- The FSM and response path live in `spi_cmd_regfile`.

## Test plan
- Reset values: reset with `RESET_VAL`=24'h000005 and NUM_REGS=4.
  - Expect `reg_out` = all registers 5.
  - Expect `rd_ack`, `wr_en` and `reg_wr` all 0.
- Write then read: write word 0x123456_41 (WRITE, addr 1), then read word 0x000000_81.
  - Expect `reg_wr`=4'b0010 for one cycle.
  - Expect `wr_data`=24'h123456 with a single `wr_en`.
- Inverted write: write word 0x00FF00_C2 (WRITE_INV, addr 2), then read addr 2.
  - Expect `wr_data`=24'hFF00FF.
- Back-pressure: read with `wr_buffer_free` held 0 for 20 cycles while a second word is available.
  - Expect no `wr_en` and no second `rd_ack` during the hold.
  - After release: `wr_en` one cycle, then the second word is acknowledged.
- Invalid address: read addr 10 with NUM_REGS=4.
  - Expect 24'hFFFFFF.
  - With `SPI_CMD_ERRCNT_EN`, a following read of addr 63 returns 24'h000001.
  - A write to addr 63 then clears it to 0.
- Reset in RESP: assert `resetn`=0 while in RESP with the buffer not free.
  - Expect no `wr_en` after release.
  - Expect registers back to `RESET_VAL`.
